div_card: RTL and testbench

Multi-cycle 8-bit unsigned restoring divider that supplies the `div_res` input of the mainboard data mux, which is currently tied to zero. It takes operands from the two register-read muxes (`a`, `b`) and returns a quotient for the destination register and a remainder for the high-result register, in the same way as the multiplier's `prod[15:8]`. It is the divide stage next to the AddCard and Multiplier. It also drives a stall so the mainboard holds `pc_reg`/`op` while a divide is in flight.

---
 rtl/div_pkg.sv | 15 +
 rtl/div_step.sv | 32 +++
 rtl/div_card.sv | 97 +++++++++
 tb/tb_div_card.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and sizes for the divide card.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package div_pkg;

    localparam int DIV_WIDTH = 8;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_RUN,
        DIV_DONE
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
// Latency: combinational.
// Backpressure: none; evaluated every cycle by the owning FSM.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem_p,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted_dat;
    logic [WIDTH+1:0] diff_dat;
    logic             unused_msbs;

    // Partial remainder with the next dividend bit appended (WIDTH+1 bits).
    assign shifted_dat = {rem_p, q_msb};

    // One extra bit so the top bit is a clean borrow flag.
    assign diff_dat = {1'b0, shifted_dat} - {2'b00, divisor};

    // No borrow means the divisor fits: quotient bit is 1 and keep the difference.
    assign q_bit    = ~diff_dat[WIDTH+1];
    assign rem_next = q_bit ? diff_dat[WIDTH-1:0] : shifted_dat[WIDTH-1:0];

    // The partial remainder is always below the divisor, so the dropped bits are
    // zero whenever their value is selected.
    assign unused_msbs = ^{diff_dat[WIDTH], shifted_dat[WIDTH]};

endmodule

// File: rtl/div_card.sv
// Multi-cycle unsigned restoring divider; quotient to div_res, remainder to the high register.
// Latency: WIDTH+1 edges from accept to done (1 edge for divide-by-zero).
// Backpressure: busy stalls PC/op; start is ignored while RUN or DONE, not queued.
module div_card
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             dz
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] rem_p;
    logic [WIDTH-1:0] q_sr;
    logic             dz_r;
    logic [WIDTH-1:0] rem_next;
    logic             q_bit;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_p    (rem_p),
        .q_msb    (q_sr[WIDTH-1]),
        .divisor  (divisor),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    // FSM, operand capture and one restoring step per RUN edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= DIV_IDLE;
            cnt     <= '0;
            divisor <= '0;
            rem_p   <= '0;
            q_sr    <= '0;
            dz_r    <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        if (b == '0) begin
                            // Divide-by-zero resolves immediately with the conventional result.
                            q_sr  <= '1;
                            rem_p <= a;
                            dz_r  <= 1'b1;
                            state <= DIV_DONE;
                        end else begin
                            divisor <= b;
                            rem_p   <= '0;
                            q_sr    <= a;
                            dz_r    <= 1'b0;
                            cnt     <= CNT_W'(WIDTH - 1);
                            state   <= DIV_RUN;
                        end
                    end
                end
                DIV_RUN: begin
                    // Dividend bits leave the top of q_sr as quotient bits enter the bottom.
                    rem_p <= rem_next;
                    q_sr  <= {q_sr[WIDTH-2:0], q_bit};
                    cnt   <= cnt - CNT_W'(1);
                    if (cnt == '0) begin
                        state <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    state <= DIV_IDLE;
                end
                default: begin
                    state <= DIV_IDLE;
                end
            endcase
        end
    end

    // Status decoded straight from the state register; results come from the working registers.
    assign busy = (state == DIV_RUN);
    assign done = (state == DIV_DONE);
    assign quot = q_sr;
    assign rem  = rem_p;
    assign dz   = dz_r;

endmodule

// File: tb/tb_div_card.sv
// Directed and randomised checks of the restoring divider against hand-computed results.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_div_card;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] quot;
    logic [7:0] rem;
    logic       dz;

    int n_cmp;
    int n_err;
    logic done_d;

    div_card #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .quot  (quot),
        .rem   (rem),
        .dz    (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // Protocol monitor: done is one cycle wide and never overlaps busy.
    always @(negedge clk) begin
        chk("busy_done_excl", {31'd0, busy & done}, 32'd0);
        chk("done_width", {31'd0, done & done_d}, 32'd0);
        done_d = done;
    end

    // Present operands with start for one edge; returns at the first negedge after accept.
    task automatic start_op(input logic [7:0] ta, input logic [7:0] tb_v);
        a = ta;
        b = tb_v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count cycles until done, bounded; lat counts negedges since the accept edge.
    task automatic wait_done(input int base, output int lat, output int nb);
        lat = base;
        nb  = 0;
        while (!done && lat < 20) begin
            if (busy) nb++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_div(input logic [7:0] ta, input logic [7:0] tb_v,
                           input logic [7:0] eq, input logic [7:0] er, input logic ed);
        int lat;
        int nb;
        int exp_lat;
        exp_lat = (tb_v == 8'd0) ? 1 : 9;
        start_op(ta, tb_v);
        wait_done(1, lat, nb);
        chk("latency", lat, exp_lat);
        chk("busy_cycles", nb, exp_lat - 1);
        chk("quot", {24'd0, quot}, {24'd0, eq});
        chk("rem", {24'd0, rem}, {24'd0, er});
        chk("dz", {31'd0, dz}, {31'd0, ed});
        @(negedge clk);
        chk("hold_quot", {24'd0, quot}, {24'd0, eq});
        chk("hold_rem", {24'd0, rem}, {24'd0, er});
        chk("hold_dz", {31'd0, dz}, {31'd0, ed});
        chk("idle_done", {31'd0, done}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int lat;
        int nb;
        int ndone;
        logic [7:0] ra;
        logic [7:0] rb;

        n_cmp  = 0;
        n_err  = 0;
        done_d = 1'b0;
        rst    = 1'b1;
        start  = 1'b0;
        a      = 8'd0;
        b      = 8'd0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_dz", {31'd0, dz}, 32'd0);
        chk("rst_quot", {24'd0, quot}, 32'd0);
        chk("rst_rem", {24'd0, rem}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Main directed vectors: 200/7 = 28 r 4 and the boundary operands.
        run_div(8'd200, 8'd7, 8'd28, 8'd4, 1'b0);
        run_div(8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
        run_div(8'd5, 8'd9, 8'd0, 8'd5, 1'b0);
        run_div(8'd0, 8'd3, 8'd0, 8'd0, 1'b0);
        run_div(8'd255, 8'd255, 8'd1, 8'd0, 1'b0);
        run_div(8'd100, 8'd0, 8'hFF, 8'd100, 1'b1);
        run_div(8'd200, 8'd7, 8'd28, 8'd4, 1'b0);

        // A start during RUN with new operands must be ignored.
        start_op(8'd200, 8'd7);
        @(negedge clk);
        @(negedge clk);
        a = 8'd9;
        b = 8'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(4, lat, nb);
        chk("ign_latency", lat, 9);
        chk("ign_quot", {24'd0, quot}, 32'd28);
        chk("ign_rem", {24'd0, rem}, 32'd4);
        @(negedge clk);
        chk("ign_no_retrigger", {31'd0, busy}, 32'd0);

        // Reset mid-RUN aborts: outputs clear at once and no done follows.
        start_op(8'd200, 8'd7);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_quot", {24'd0, quot}, 32'd0);
        chk("abort_rem", {24'd0, rem}, 32'd0);
        chk("abort_dz", {31'd0, dz}, 32'd0);
        ndone = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) ndone++;
        end
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        run_div(8'd81, 8'd9, 8'd9, 8'd0, 1'b0);

        // Randomised operands, every eighth with a zero divisor.
        for (int i = 0; i < 300; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = (i % 8 == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            if (rb == 8'd0)
                run_div(ra, rb, 8'hFF, ra, 1'b1);
            else
                run_div(ra, rb, ra / rb, ra % rb, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
